// File: rtl/opb_slave_pkg.sv
// opb_slave_pkg: register map, bit positions, bus FSM states and OPB bit-order helpers
package opb_slave_pkg;
  localparam logic [5:0] DATA_OFS = 6'd0;
  localparam logic [5:0] STATUS_OFS = 6'd1;
  localparam logic [5:0] CTRL_OFS = 6'd2;
  localparam int ST_NEW = 0;
  localparam int ST_EN = 1;
  localparam int ST_OVR = 16;
  localparam int CT_EN = 0;
  localparam int CT_CLR = 1;
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  function automatic logic [31:0] be2le(input logic [0:31] b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = b[31-i];
    return r;
  endfunction
  function automatic logic [0:31] le2be(input logic [31:0] l);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[31-i] = l[i];
    return r;
  endfunction
endpackage

// File: rtl/opb_slave_if.sv
// opb_slave_if: OPB address decode and IDLE/ACK/WAIT handshake producing one ack per select
module opb_slave_if
  import opb_slave_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0110C100,
  parameter logic [31:0] C_HIGHADDR = 32'h0110C1FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:31] abus,
  input  logic [0:3]  be,
  input  logic [0:31] dbus,
  input  logic        rnw,
  input  logic        select,
  input  logic [31:0] rd_data,
  output logic        xfer_ack,
  output logic [31:0] dout,
  output logic        rd_stb,
  output logic        wr_stb,
  output logic [5:0]  ofs,
  output logic [5:0]  xfer_ofs,
  output logic [31:0] wr_data,
  output logic        wr_lsb
);
  state_t state;
  logic hit;
  logic unused_bits;
  assign hit = select && abus >= C_BASEADDR && abus <= C_HIGHADDR;
  assign ofs = abus[24:29];
  assign unused_bits = ^{abus[30:31], be[0:2]};
  // handshake FSM; ack, read data and strobes are registered so they all live in the ACK cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      xfer_ack <= 1'b0;
      dout <= '0;
      rd_stb <= 1'b0;
      wr_stb <= 1'b0;
      xfer_ofs <= '0;
      wr_data <= '0;
      wr_lsb <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          state <= ACK;
          xfer_ack <= 1'b1;
          dout <= rnw ? rd_data : '0;
          rd_stb <= rnw;
          wr_stb <= !rnw;
          xfer_ofs <= ofs;
          wr_data <= be2le(dbus);
          wr_lsb <= be[3];
        end
        ACK: begin
          state <= WAIT;
          xfer_ack <= 1'b0;
          dout <= '0;
          rd_stb <= 1'b0;
          wr_stb <= 1'b0;
        end
        WAIT: if (!select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/opb_snapshot_simulink2ppc.sv
// opb_snapshot_simulink2ppc: fabric-to-PowerPC snapshot register with new-data flag and overrun counter
module opb_snapshot_simulink2ppc
  import opb_slave_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0110C100,
  parameter logic [31:0] C_HIGHADDR = 32'h0110C1FF,
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter string C_FAMILY = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_new_data,
  output logic                    user_enable
);
  logic [31:0] hold, rd_data, status, dout, wr_data;
  logic [15:0] ovr;
  logic [5:0] ofs, xfer_ofs;
  logic new_flag, enable, rd_stb, wr_stb, wr_lsb;
  logic cap, rd_clr, ctrl_wr, clr_ovr;
  logic unused;
  opb_slave_if #(.C_BASEADDR(C_BASEADDR), .C_HIGHADDR(C_HIGHADDR)) u_if (
    .clk(OPB_Clk),
    .rst_n(OPB_Rst_n),
    .abus(OPB_ABus),
    .be(OPB_BE),
    .dbus(OPB_DBus),
    .rnw(OPB_RNW),
    .select(OPB_select),
    .rd_data(rd_data),
    .xfer_ack(Sl_xferAck),
    .dout(dout),
    .rd_stb(rd_stb),
    .wr_stb(wr_stb),
    .ofs(ofs),
    .xfer_ofs(xfer_ofs),
    .wr_data(wr_data),
    .wr_lsb(wr_lsb)
  );
  assign Sl_DBus = le2be(dout);
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_new_data = new_flag;
  assign user_enable = enable;
  assign cap = user_data_valid && enable;
  assign rd_clr = rd_stb && xfer_ofs == DATA_OFS;
  assign ctrl_wr = wr_stb && xfer_ofs == CTRL_OFS && wr_lsb;
  assign clr_ovr = ctrl_wr && wr_data[CT_CLR];
  assign unused = ^{OPB_seqAddr, wr_data[31:2], C_FAMILY == ""};
  // status word assembly and read mux on the live word offset
  always_comb begin
    status = '0;
    status[ST_NEW] = new_flag;
    status[ST_EN] = enable;
    status[ST_OVR+:16] = ovr;
    rd_data = ofs == DATA_OFS ? hold : ofs == STATUS_OFS ? status : '0;
  end
  // capture, new-data flag, overrun count and enable; a capture beats a same-cycle DATA read clear
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
    if (!OPB_Rst_n) begin
      hold <= '0;
      new_flag <= 1'b0;
      ovr <= '0;
      enable <= 1'b0;
    end else begin
      hold <= cap ? user_data_in : hold;
      new_flag <= cap || (new_flag && !rd_clr);
      ovr <= clr_ovr ? '0 : (cap && new_flag && ovr != 16'hFFFF) ? ovr + 16'd1 : ovr;
      enable <= ctrl_wr ? wr_data[CT_EN] : enable;
    end
endmodule

// File: tb/tb_opb_snapshot_simulink2ppc.sv
// tb_opb_snapshot_simulink2ppc: randomized bench checking the snapshot slave against a behavioural model
module tb_opb_snapshot_simulink2ppc;
  localparam logic [31:0] BASE = 32'h0110C100;
  localparam logic [31:0] HIGH = 32'h0110C1FF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [0:31] abus, dbus, sl_dbus;
  logic [0:3] be;
  logic rnw, select, seq;
  logic xack, eack, retry, tout;
  logic [31:0] ud, t_data, r_data;
  logic uv, t_valid, r_valid, rand_on;
  logic unew, uen;
  assign uv = rand_on ? r_valid : t_valid;
  assign ud = rand_on ? r_data : t_data;
  opb_snapshot_simulink2ppc dut (
    .OPB_Clk(clk),
    .OPB_Rst_n(rst_n),
    .OPB_ABus(abus),
    .OPB_BE(be),
    .OPB_DBus(dbus),
    .OPB_RNW(rnw),
    .OPB_select(select),
    .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus),
    .Sl_xferAck(xack),
    .Sl_errAck(eack),
    .Sl_retry(retry),
    .Sl_toutSup(tout),
    .user_data_in(ud),
    .user_data_valid(uv),
    .user_new_data(unew),
    .user_enable(uen)
  );
  int compared = 0;
  int mismatched = 0;
  logic [31:0] m_hold, m_cd;
  logic [15:0] m_ovr;
  logic m_new, m_en, m_clr, m_ctrl, m_cap;
  bit in_ack;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_read(input logic [5:0] o);
    if (o == 6'd0) return m_hold;
    if (o == 6'd1) return {m_ovr, 14'd0, m_en, m_new};
    return 32'd0;
  endfunction
  // reference model: what the snapshot registers must hold after each clock edge
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_hold = 0;
      m_ovr = 0;
      m_new = 0;
      m_en = 0;
    end else begin
      m_cap = uv && m_en;
      if (m_cap) begin
        if (m_new && m_ovr != 16'hFFFF) m_ovr = m_ovr + 1;
        m_hold = ud;
      end
      if (m_ctrl) begin
        if (m_cd[1]) m_ovr = 0;
        m_en = m_cd[0];
      end
      m_new = m_cap || (m_new && !m_clr);
    end
  // per-cycle comparison of mirrored outputs and the quiet bus outside ack cycles
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (!in_ack) begin
        chk("idle_ack", {31'd0, xack}, 32'd0);
        chk("idle_dbus", sl_dbus, 32'd0);
      end
      chk("user_new_data", {31'd0, unew}, {31'd0, m_new});
      chk("user_enable", {31'd0, uen}, {31'd0, m_en});
      chk("tied", {29'd0, eack, retry, tout}, 32'd0);
    end
  end
  // random user strobes for the randomized phase
  always @(negedge clk)
    if (rand_on) begin
      r_valid = 1'($urandom_range(0, 1));
      r_data = $urandom;
    end
  task automatic bus(input bit rd, input logic [31:0] addr, input logic [31:0] wd, input logic [0:3] bm,
                     input int hold, input bit ack_stb, input logic [31:0] sd, output logic [31:0] q);
    bit hit;
    logic [31:0] exp;
    logic [5:0] o;
    hit = addr >= BASE && addr <= HIGH;
    o = addr[7:2];
    @(negedge clk);
    abus = addr;
    dbus = wd;
    be = bm;
    rnw = rd;
    select = 1'b1;
    exp = (hit && rd) ? m_read(o) : 32'd0;
    @(negedge clk);
    if (hit) begin
      in_ack = 1'b1;
      chk("ack", {31'd0, xack}, 32'd1);
      chk("rdata", sl_dbus, exp);
      m_clr = rd && o == 6'd0;
      m_ctrl = !rd && o == 6'd2 && bm[3];
      m_cd = wd;
    end else chk("miss_ack", {31'd0, xack}, 32'd0);
    if (ack_stb) begin
      t_valid = 1'b1;
      t_data = sd;
    end
    q = sl_dbus;
    @(negedge clk);
    in_ack = 1'b0;
    m_clr = 1'b0;
    m_ctrl = 1'b0;
    t_valid = 1'b0;
    for (int i = 2; i < hold; i++) @(negedge clk);
    select = 1'b0;
    rnw = 1'b0;
    abus = '0;
    dbus = '0;
  endtask
  task automatic rd_reg(input int o, output logic [31:0] q);
    bus(1'b1, BASE + 32'(o) * 4, 32'd0, 4'b1111, 2, 1'b0, 32'd0, q);
  endtask
  task automatic wr_reg(input int o, input logic [31:0] d, input logic [0:3] bm);
    logic [31:0] q;
    bus(1'b0, BASE + 32'(o) * 4, d, bm, 2, 1'b0, 32'd0, q);
  endtask
  task automatic strobe(input logic [31:0] d);
    @(negedge clk);
    t_valid = 1'b1;
    t_data = d;
    @(negedge clk);
    t_valid = 1'b0;
  endtask
  logic [31:0] q;
  initial begin
    abus = '0;
    dbus = '0;
    be = '0;
    rnw = 1'b0;
    select = 1'b0;
    seq = 1'b0;
    t_valid = 1'b0;
    t_data = '0;
    r_valid = 1'b0;
    r_data = '0;
    rand_on = 1'b0;
    m_clr = 1'b0;
    m_ctrl = 1'b0;
    m_cd = '0;
    in_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ack", {31'd0, xack}, 32'd0);
    chk("rst_dbus", sl_dbus, 32'd0);
    rd_reg(1, q);
    chk("rst_status", q, 32'h0);
    rd_reg(0, q);
    chk("rst_data", q, 32'h0);
    wr_reg(2, 32'h1, 4'b1111);
    strobe(32'hDEADBEEF);
    chk("new_after_cap", {31'd0, unew}, 32'd1);
    rd_reg(1, q);
    chk("status_new", q, 32'h00000003);
    rd_reg(0, q);
    chk("data_deadbeef", q, 32'hDEADBEEF);
    rd_reg(1, q);
    chk("status_cleared", q, 32'h00000002);
    strobe(32'h1);
    strobe(32'h2);
    strobe(32'h3);
    rd_reg(1, q);
    chk("status_ovr2", q, 32'h00020003);
    rd_reg(0, q);
    chk("data_3", q, 32'h3);
    wr_reg(2, 32'h3, 4'b1111);
    rd_reg(1, q);
    chk("status_ovr_clr", q, 32'h00000002);
    strobe(32'h44);
    bus(1'b1, BASE, 32'd0, 4'b1111, 2, 1'b1, 32'h55, q);
    chk("simul_old", q, 32'h44);
    chk("simul_flag", {31'd0, unew}, 32'd1);
    rd_reg(0, q);
    chk("simul_new", q, 32'h55);
    bus(1'b1, BASE + 4, 32'd0, 4'b1111, 5, 1'b0, 32'd0, q);
    chk("hold5_status", q, 32'h00010002);
    bus(1'b1, HIGH + 4, 32'd0, 4'b1111, 3, 1'b0, 32'd0, q);
    bus(1'b1, BASE - 4, 32'd0, 4'b1111, 3, 1'b0, 32'd0, q);
    rd_reg(5, q);
    chk("ofs5", q, 32'h0);
    rd_reg(2, q);
    chk("ctrl_reads0", q, 32'h0);
    wr_reg(0, 32'hFFFFFFFF, 4'b1111);
    rd_reg(0, q);
    chk("data_ro", q, 32'h55);
    wr_reg(2, 32'h0, 4'b1110);
    chk("be_masked", {31'd0, uen}, 32'd1);
    t_data = 32'h1234;
    t_valid = 1'b1;
    repeat (70000) @(negedge clk);
    t_valid = 1'b0;
    rd_reg(1, q);
    chk("ovr_sat", q, 32'hFFFF0003);
    bus(1'b0, BASE + 8, 32'h3, 4'b1111, 2, 1'b1, 32'h99, q);
    rd_reg(1, q);
    chk("clr_wins", q, 32'h00000003);
    rd_reg(0, q);
    chk("clr_data", q, 32'h99);
    rand_on = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k < 5) bus(1'b1, BASE + 32'($urandom_range(0, 7)) * 4, 32'd0, 4'b1111, int'($urandom_range(2, 4)), 1'b0, 32'd0, q);
      else if (k < 8) bus(1'b0, BASE + 8, {$urandom_range(0, 1) == 0 ? 30'd0 : 30'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0)},
                          4'($urandom), int'($urandom_range(2, 3)), 1'b0, 32'd0, q);
      else if (k < 9) bus(1'b0, BASE + 32'($urandom_range(0, 1)) * 4, $urandom, 4'b1111, 2, 1'b0, 32'd0, q);
      else bus(1'b1, HIGH + 4 + 32'($urandom_range(0, 64)) * 4, 32'd0, 4'b1111, 2, 1'b0, 32'd0, q);
    end
    rand_on = 1'b0;
    wr_reg(2, 32'h1, 4'b1111);
    strobe(32'hA5A5A5A5);
    @(negedge clk);
    abus = BASE + 4;
    rnw = 1'b1;
    be = 4'b1111;
    select = 1'b1;
    @(negedge clk);
    in_ack = 1'b1;
    chk("pre_rst_ack", {31'd0, xack}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, xack}, 32'd0);
    chk("rst_mid_dbus", sl_dbus, 32'd0);
    chk("rst_mid_new", {31'd0, unew}, 32'd0);
    chk("rst_mid_en", {31'd0, uen}, 32'd0);
    in_ack = 1'b0;
    select = 1'b0;
    rnw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_reg(1, q);
    chk("post_rst_status", q, 32'h0);
    rd_reg(0, q);
    chk("post_rst_data", q, 32'h0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/opb_snapshot_simulink2ppc.md
Name: opb_snapshot_simulink2ppc

Overview:
- OPB slave carrying data from fabric to the PowerPC, the opposite direction of the ppc2simulink software registers.
- The user side strobes a 32-bit word into a holding register. The CPU reads that word, a status word with a new-data flag and an overrun count, and writes a control word.
- Single clock domain: the user logic runs on OPB_Clk, so there is no CDC.

Parameters:
- C_BASEADDR, 32'h0110C100: first byte address of the 256-byte window.
- C_HIGHADDR, 32'h0110C1FF: last byte address of the window.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width.
- C_FAMILY, "virtex6": target family, informational only.

Ports:
- OPB_Clk, in, 1: sole clock; the user side also runs on it.
- OPB_Rst_n, in, 1: asynchronous, active-low reset.
- OPB_ABus, in, [0:31]: address.
- OPB_BE, in, [0:3]: byte enables.
- OPB_DBus, in, [0:31]: write data.
- OPB_RNW, in, 1: 1 = read.
- OPB_select, in, 1: transfer request.
- OPB_seqAddr, in, 1: ignored.
- Sl_DBus, out, [0:31]: read data; zero except in the ack cycle.
- Sl_xferAck, out, 1: one-cycle transfer acknowledge.
- Sl_errAck, out, 1: tied 0.
- Sl_retry, out, 1: tied 0.
- Sl_toutSup, out, 1: tied 0.
- user_data_in, in, [31:0]: word to capture.
- user_data_valid, in, 1: capture strobe, one cycle per word.
- user_new_data, out, 1: mirror of the new-data flag.
- user_enable, out, 1: mirror of the capture-enable control bit.

Behaviour:
- Bit mapping: user bit n = OPB bit (31-n).
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word offset = OPB_ABus[24:29].
- Register map:
  - Offset 0 DATA (RO): holding register.
  - Offset 1 STATUS (RO): bit0 new_flag, bit1 enable, [31:16] overrun_cnt.
  - Offset 2 CTRL (RW): bit0 enable, bit1 clr_ovr, self-clearing and reads as 0.
  - Other offsets in range: read 0, writes ignored, still acked.
- Bus FSM:
  - IDLE: on hit, go to ACK.
  - ACK: Sl_xferAck=1 for exactly one cycle, Sl_DBus = selected register (read) or 0 (write), then go to WAIT.
  - WAIT: stay until OPB_select=0, then go to IDLE. This prevents a double ack.
  - Latency: ack is in the 2nd cycle after select is sampled high.
  - Read data is sampled at entry to ACK.
- CTRL write:
  - Takes effect at the ACK cycle edge.
  - Applies only if OPB_BE[3]=1; otherwise it is acked with no effect.
  - Writes to DATA or STATUS are acked and ignored.
- Capture:
  - When user_data_valid=1 and enable=1, the holding register loads user_data_in and new_flag is set next cycle.
  - When enable=0, strobes are ignored entirely.
- Overrun: a capture while new_flag=1 increments overrun_cnt, saturating at 16'hFFFF. The new data still overwrites the holding register.
- DATA read ack clears new_flag.
- Simultaneous capture and DATA-read ack in the same cycle:
  - The read returns the old value.
  - new_flag ends at 1 and the new value is held.
  - Overrun increments only if new_flag was already 1 before that cycle.
- Simultaneous clr_ovr and overrun increment: the clear wins, so the count is 0.
- Reset (any time, including mid-transfer):
  - All registers are 0: FSM IDLE, Sl_xferAck=0, Sl_DBus=0, holding=0, new_flag=0, overrun_cnt=0.
  - Outputs: enable=0, user_new_data=0, user_enable=0.
  - A transfer interrupted by reset is never acked; the master times out.
- Miss (address outside the window): no ack, Sl_DBus=0.

Decomposition:
- Shared package opb_slave_pkg:
  - Register offset constants DATA_OFS=0, STATUS_OFS=1, CTRL_OFS=2.
  - STATUS and CTRL bit-position constants.
  - FSM state enum {IDLE, ACK, WAIT}.
  - Function for big-endian/little-endian bit reversal.
- One sub-module, opb_slave_if: address decode plus the IDLE/ACK/WAIT FSM. It outputs rd_stb, wr_stb, word offset and latched write data, and accepts read data. The top level holds the register file and capture logic.

Test Plan:
- Reset values: hold OPB_Rst_n=0, then release. Sl_xferAck=0, Sl_DBus=0, STATUS read = 0x00000000, DATA read = 0.
- Basic capture and read:
  - Write CTRL=0x1 with BE=4'b1111, then pulse valid with 0xDEADBEEF.
  - user_new_data=1 next cycle, STATUS=0x00000003.
  - DATA read = 0xDEADBEEF, acked in the 2nd cycle.
  - STATUS afterwards = 0x00000002.
- Overrun:
  - Enabled, 3 strobes (0x1, 0x2, 0x3) with no read: STATUS=0x00020003, DATA=0x3.
  - CTRL write 0x3 gives STATUS=0x00000003 after the DATA read clears the flag... precisely: CTRL write 0x3 gives overrun 0; after the DATA read STATUS=0x00000002.
  - 70000 strobes saturate the count at 0xFFFF.
- Simultaneous event: strobe 0x55 in the same cycle as a DATA-read ack with old data 0x44. Read returns 0x44, new_flag=1, next DATA read = 0x55.
- Handshake:
  - Hold OPB_select high 5 cycles: exactly one xferAck pulse.
  - Address C_HIGHADDR+4: no ack.
  - Address offset 5: reads 0 with ack.
  - CTRL write with BE=4'b1110: enable unchanged.
- Reset mid-transfer: assert OPB_Rst_n=0 during ACK. Sl_xferAck drops immediately (async), all state returns to 0, and the next read is acked normally.
